// File: rtl/display_mode_sequencer.sv
// rtl/display_mode_sequencer.sv - debounced key / direct-load display source sequencer, frame-aligned switching
// Optional auto-advance on idle frames is built only when AUTO_CYCLE_EN is defined.
module display_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLANK_FRAMES    = 1,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iKey_n,
  input  logic       iLoad,
  input  logic [2:0] iLoad_sel,
  input  logic       iFrame_start,
  input  logic       iAuto_en,
  output logic [2:0] oSelect,
  output logic       oPending,
  output logic       oSwitch,
  output logic       oBlank
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 2);
  localparam int BW = $clog2(BLANK_FRAMES + 2);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  typedef enum logic [1:0] {IDLE, PENDING, BLANK} state_t;

  state_t        state_q, state_d;
  logic          key_s1_q, key_s1_d;
  logic          key_s2_q, key_s2_d;
  logic          deb_q, deb_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    target_q, target_d;
  logic          pend_q, pend_d;
  logic          switch_q, switch_d;

  logic          press;
  logic          load_ok;
  logic          auto_req;
  logic          req;
  logic [2:0]    base;
  logic [2:0]    new_tgt;

  function automatic logic [2:0] advance(input logic [2:0] m);
    return (m == 3'd0 || m >= 3'd4) ? 3'd1 : m + 3'd1;
  endfunction

`ifdef AUTO_CYCLE_EN
  localparam int AW = $clog2(AUTO_FRAMES + 2);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;

  // Idle frames are only counted while nothing else is asking for a switch.
  always_comb begin
    auto_req   = 1'b0;
    auto_cnt_d = '0;
    if (state_q == IDLE && iAuto_en && !load_ok && !press) begin
      auto_cnt_d = auto_cnt_q;
      if (iFrame_start) begin
        if (auto_cnt_q == AUTO_LAST) begin
          auto_req   = 1'b1;
          auto_cnt_d = '0;
        end else begin
          auto_cnt_d = auto_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) auto_cnt_q <= '0;
    else         auto_cnt_q <= auto_cnt_d;
  end
`else
  logic unused_auto_en;
  assign unused_auto_en = iAuto_en;
  assign auto_req       = 1'b0;
`endif

  always_comb begin
    key_s1_d = iKey_n;
    key_s2_d = key_s1_q;
    deb_d    = deb_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (key_s2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = key_s2_q;
        press = ~key_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Direct load beats a key press; an out-of-range load is no request at all.
    load_ok  = iLoad && (iLoad_sel <= 3'd4);
    req      = load_ok | press | auto_req;
    base     = pend_q ? target_q : sel_q;
    new_tgt  = load_ok ? iLoad_sel : advance(base);
    target_d = req ? new_tgt : target_q;
    pend_d   = pend_q | req;

    state_d     = state_q;
    sel_d       = sel_q;
    switch_d    = 1'b0;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      IDLE: begin
        if (req) state_d = PENDING;
      end
      PENDING: begin
        // Applies the target held before this cycle; a coinciding request stays queued.
        if (iFrame_start) begin
          sel_d       = target_q;
          switch_d    = 1'b1;
          pend_d      = req;
          blank_cnt_d = '0;
          if (BLANK_FRAMES > 0) state_d = BLANK;
          else                  state_d = req ? PENDING : IDLE;
        end
      end
      BLANK: begin
        if (iFrame_start) begin
          if (blank_cnt_q == BLANK_LAST) begin
            blank_cnt_d = '0;
            state_d     = pend_d ? PENDING : IDLE;
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      key_s1_q    <= 1'b1;
      key_s2_q    <= 1'b1;
      deb_q       <= 1'b1;
      db_cnt_q    <= '0;
      blank_cnt_q <= '0;
      sel_q       <= 3'd1;
      target_q    <= 3'd1;
      pend_q      <= 1'b0;
      switch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
      deb_q       <= deb_d;
      db_cnt_q    <= db_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      sel_q       <= sel_d;
      target_q    <= target_d;
      pend_q      <= pend_d;
      switch_q    <= switch_d;
    end
  end

  assign oSelect  = sel_q;
  assign oPending = pend_q;
  assign oSwitch  = switch_q;
  assign oBlank   = (state_q == BLANK);

endmodule

// File: tb/tb_display_mode_sequencer.sv
// tb/tb_display_mode_sequencer.sv - vector table, directed corner sequences and random run vs. reference model
// Expectations for auto-advance follow AUTO_CYCLE_EN as defined for the build.
module tb_display_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, key_n, load, frame, auto_en;
  logic [2:0] load_sel;
  logic [2:0] sel;
  logic       pend, sw, blank;

  int n_cmp = 0;
  int n_err = 0;

  display_mode_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .BLANK_FRAMES(1),
    .AUTO_FRAMES(3)
  ) dut (
    .iClk(clk),
    .iRst_n(rst_n),
    .iKey_n(key_n),
    .iLoad(load),
    .iLoad_sel(load_sel),
    .iFrame_start(frame),
    .iAuto_en(auto_en),
    .oSelect(sel),
    .oPending(pend),
    .oSwitch(sw),
    .oBlank(blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [2:0] lsel;
    logic       fr;
    logic [2:0] es;
    logic       ep;
    logic       esw;
    logic       eb;
  } vec_t;

  vec_t vecs[15];

  // Reference model: applied mode, requested mode, frames of blanking left.
  logic       m_s1, m_s2, m_deb, m_pend, m_sw;
  logic [3:0] m_hist;
  logic [2:0] m_sel, m_tgt;
  int         m_blank_left, m_auto;

  function automatic logic [2:0] next_mode(input logic [2:0] m);
    return 3'((int'(m) % 4) + 1);
  endfunction

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_hist = 4'hF; m_deb = 1'b1;
    m_sel = 3'd1; m_tgt = 3'd1; m_pend = 1'b0; m_sw = 1'b0;
    m_blank_left = 0; m_auto = 0;
  endtask

  task automatic model_step();
    logic press, load_ok, manual, auto_req, req, idle;
    logic [2:0] newt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_hist = {m_hist[2:0], m_s2};
    press  = 1'b0;
    if (m_deb && m_hist == 4'b0000) begin
      m_deb = 1'b0;
      press = 1'b1;
    end else if (!m_deb && m_hist == 4'b1111) begin
      m_deb = 1'b1;
    end
    m_s2 = m_s1;
    m_s1 = key_n;
    load_ok  = load && (load_sel <= 3'd4);
    manual   = load_ok || press;
    idle     = !m_pend && m_blank_left == 0;
    auto_req = 1'b0;
`ifdef AUTO_CYCLE_EN
    if (idle && auto_en && !manual) begin
      if (frame) begin
        m_auto++;
        if (m_auto == 3) begin
          auto_req = 1'b1;
          m_auto   = 0;
        end
      end
    end else begin
      m_auto = 0;
    end
`endif
    req  = manual || auto_req;
    newt = load_ok ? load_sel : next_mode(m_pend ? m_tgt : m_sel);
    m_sw = 1'b0;
    if (m_blank_left == 0 && m_pend && frame) begin
      m_sel = m_tgt;
      m_sw = 1'b1;
      m_blank_left = 1;
      m_pend = 1'b0;
    end else if (m_blank_left > 0 && frame) begin
      m_blank_left--;
    end
    if (req) begin
      m_tgt  = newt;
      m_pend = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] es, input logic ep, input logic esw, input logic eb);
    n_cmp++;
    if ({sel, pend, sw, blank} !== {es, ep, esw, eb}) begin
      n_err++;
      $display("FAIL %s: got sel=%0d pend=%0b sw=%0b blank=%0b, expected sel=%0d pend=%0b sw=%0b blank=%0b",
               name, sel, pend, sw, blank, es, ep, esw, eb);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; key_n = 1'b1; load = 1'b0; load_sel = 3'd0; frame = 1'b0; auto_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic press_key();
    key_n = 1'b0;
    repeat (10) tick();
    key_n = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    int found;
    int hold;
    vecs[0]  = '{1'b1, 3'd3, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3'd6, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 3'd4, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'd2, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'd2, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 3'd7, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 3'd5, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};

    do_reset();
    chk("reset", 3'd1, 1'b0, 1'b0, 1'b0);

    // Clean press: request visible 6 edges after the key goes low.
    key_n = 1'b0;
    found = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (pend === 1'b1) begin
        found = i;
        break;
      end
    end
    chk_int("press_latency", found, 6);
    pulse_frame();
    chk("press_apply", 3'd2, 1'b0, 1'b1, 1'b1);
    tick();
    chk("blank_hold", 3'd2, 1'b0, 1'b0, 1'b1);
    pulse_frame();
    chk("blank_end", 3'd2, 1'b0, 1'b0, 1'b0);
    key_n = 1'b1;
    repeat (12) tick();
    chk("release_no_press", 3'd2, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      key_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    key_n = 1'b0;
    repeat (12) tick();
    chk("bounce_one_press", 3'd2, 1'b1, 1'b0, 1'b0);
    pulse_frame();
    chk("bounce_apply", 3'd3, 1'b0, 1'b1, 1'b1);
    pulse_frame();
    key_n = 1'b1;
    repeat (12) tick();

    load = 1'b1; load_sel = 3'd4;
    tick();
    load = 1'b0;
    pulse_frame();
    pulse_frame();
    chk("load4_idle", 3'd4, 1'b0, 1'b0, 1'b0);
    press_key();
    press_key();
    chk("two_presses_pending", 3'd4, 1'b1, 1'b0, 1'b0);
    pulse_frame();
    chk("wrap_4_1_2", 3'd2, 1'b0, 1'b1, 1'b1);
    pulse_frame();

    key_n = 1'b0;
    repeat (5) tick();
    load = 1'b1; load_sel = 3'd0;
    tick();
    load = 1'b0;
    chk("load_beats_press", 3'd2, 1'b1, 1'b0, 1'b0);
    pulse_frame();
    chk("load0_apply", 3'd0, 1'b0, 1'b1, 1'b1);
    pulse_frame();
    chk("press_dropped", 3'd0, 1'b0, 1'b0, 1'b0);
    key_n = 1'b1;
    repeat (12) tick();
    load = 1'b1; load_sel = 3'd6;
    tick();
    load = 1'b0;
    chk("load_sel6_ignored", 3'd0, 1'b0, 1'b0, 1'b0);

    load = 1'b1; load_sel = 3'd3;
    tick();
    load = 1'b0;
    chk("load3_pending", 3'd0, 1'b1, 1'b0, 1'b0);
    key_n = 1'b0;
    repeat (5) tick();
    pulse_frame();
    chk("press_on_apply_frame", 3'd3, 1'b1, 1'b1, 1'b1);
    pulse_frame();
    chk("blank_end_still_pending", 3'd3, 1'b1, 1'b0, 1'b0);
    pulse_frame();
    chk("second_switch", 3'd4, 1'b0, 1'b1, 1'b1);
    pulse_frame();
    key_n = 1'b1;
    repeat (12) tick();
    chk("settled", 3'd4, 1'b0, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      load = vecs[i].ld; load_sel = vecs[i].lsel; frame = vecs[i].fr;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].es, vecs[i].ep, vecs[i].esw, vecs[i].eb);
    end
    load = 1'b0; frame = 1'b0;

    do_reset();
    auto_en = 1'b1;
    pulse_frame(); tick();
    pulse_frame(); tick();
    pulse_frame();
`ifdef AUTO_CYCLE_EN
    chk("auto_request", 3'd1, 1'b1, 1'b0, 1'b0);
`else
    chk("auto_request", 3'd1, 1'b0, 1'b0, 1'b0);
`endif
    tick();
    pulse_frame();
`ifdef AUTO_CYCLE_EN
    chk("auto_apply", 3'd2, 1'b0, 1'b1, 1'b1);
`else
    chk("auto_apply", 3'd1, 1'b0, 1'b0, 1'b0);
`endif
    auto_en = 1'b0;

    do_reset();
    model_reset();
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        key_n = 1'($urandom_range(0, 1));
        hold  = int'($urandom_range(1, 12));
      end
      hold--;
      load     = ($urandom_range(0, 15) == 0);
      load_sel = 3'($urandom_range(0, 7));
      frame    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
      rst_n    = ($urandom_range(0, 799) != 0);
      model_step();
      tick();
      chk("random", m_sel, m_pend, m_sw, m_blank_left > 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
